// File: rtl/key_box_position_ctrl.sv
// ---------------------------------------------------------------------------------------------
// key_box_position_ctrl
//   Moves a BOX_W x BOX_H overlay box across the active VGA frame from one-cycle key pulses.
//   Presses accumulate into signed pending displacements. The box position is committed only on
//   the synchronized rising edge of Vsync, so the overlay never tears mid-frame. Repeated presses
//   in the same direction, within ACCEL_WIN cycles of each other, double the step size up to
//   STEP_MAX.
//
// Ports
//   Clk_50mhz   system clock
//   Rst_n       asynchronous active-low reset
//   Key_left/right/up/down   one-cycle press pulses (Clk_50mhz domain)
//   Vsync       frame sync, active high, asynchronous to Clk_50mhz
//   Box_x/Box_y committed box top-left corner
//   Step        current step size in pixels
//   Frame_upd   one-cycle pulse in the same cycle that Box_x/Box_y take a committed value
// ---------------------------------------------------------------------------------------------
module key_box_position_ctrl #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned BOX_W     = 64,
    parameter int unsigned BOX_H     = 64,
    parameter int unsigned STEP_MIN  = 1,
    parameter int unsigned STEP_MAX  = 16,
    parameter int unsigned ACCEL_WIN = 25_000_000
) (
    input  logic       Clk_50mhz,
    input  logic       Rst_n,
    input  logic       Key_left,
    input  logic       Key_right,
    input  logic       Key_up,
    input  logic       Key_down,
    input  logic       Vsync,
    output logic [9:0] Box_x,
    output logic [9:0] Box_y,
    output logic [4:0] Step,
    output logic       Frame_upd
);

    localparam int unsigned WinW = $clog2(ACCEL_WIN + 1);

    localparam logic [9:0]         XMax   = 10'(H_ACTIVE - BOX_W);
    localparam logic [9:0]         YMax   = 10'(V_ACTIVE - BOX_H);
    localparam logic [9:0]         XReset = 10'((H_ACTIVE - BOX_W) / 2);
    localparam logic [9:0]         YReset = 10'((V_ACTIVE - BOX_H) / 2);
    localparam logic [4:0]         StepLo = 5'(STEP_MIN);
    localparam logic [5:0]         StepHi = 6'(STEP_MAX);
    localparam logic [WinW-1:0]    WinEnd = WinW'(ACCEL_WIN);

    typedef enum logic [2:0] {
        DirNone,
        DirLeft,
        DirRight,
        DirUp,
        DirDown
    } dir_e;

    // Signed add that saturates at +/-1023 instead of wrapping.
    function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                   input logic signed [11:0] b);
        logic signed [12:0] s;
        s = $signed({a[11], a}) + $signed({b[11], b});
        if (s > 13'sd1023) begin
            return 12'sd1023;
        end else if (s < -13'sd1023) begin
            return -12'sd1023;
        end
        return s[11:0];
    endfunction

    // Apply pending displacement to a position and clamp into [0, lim].
    function automatic logic [9:0] clamp_pos(input logic [9:0] pos,
                                             input logic signed [11:0] pend,
                                             input logic [9:0] lim);
        logic signed [11:0] s;
        s = $signed({2'b00, pos}) + pend;
        if (s < 12'sd0) begin
            return 10'd0;
        end else if (s > $signed({2'b00, lim})) begin
            return lim;
        end
        return s[9:0];
    endfunction

    logic [9:0]         box_x_q, box_x_d;
    logic [9:0]         box_y_q, box_y_d;
    logic [4:0]         step_q, step_d;
    logic               frame_upd_q, frame_upd_d;
    logic signed [11:0] dx_pend_q, dx_pend_d;
    logic signed [11:0] dy_pend_q, dy_pend_d;
    dir_e               last_dir_q, last_dir_d;
    logic [WinW-1:0]    win_cnt_q, win_cnt_d;
    logic               vs_meta_q, vs_sync_q, vs_edge_q;

    logic               commit;
    logic               mv_l, mv_r, mv_u, mv_d, any_move, single_key;
    dir_e               key_dir;
    logic [5:0]         step_dbl;
    logic signed [11:0] delta, dx_base, dy_base;

    always_comb begin
        // Opposing keys cancel each other.
        mv_l       = Key_left  & ~Key_right;
        mv_r       = Key_right & ~Key_left;
        mv_u       = Key_up    & ~Key_down;
        mv_d       = Key_down  & ~Key_up;
        any_move   = mv_l | mv_r | mv_u | mv_d;
        single_key = $onehot({Key_left, Key_right, Key_up, Key_down});
        commit     = vs_sync_q & ~vs_edge_q;

        key_dir = DirNone;
        if (Key_left) begin
            key_dir = DirLeft;
        end else if (Key_right) begin
            key_dir = DirRight;
        end else if (Key_up) begin
            key_dir = DirUp;
        end else if (Key_down) begin
            key_dir = DirDown;
        end

        step_dbl = {step_q, 1'b0};
        step_d     = step_q;
        last_dir_d = last_dir_q;
        win_cnt_d  = win_cnt_q;
        if (win_cnt_q < WinEnd) begin
            win_cnt_d = win_cnt_q + WinW'(1);
            // Window expired: the next press starts from STEP_MIN again.
            if (win_cnt_d == WinEnd) begin
                last_dir_d = DirNone;
            end
        end

        // A press in the commit cycle lands in the freshly cleared accumulator.
        dx_base   = commit ? 12'sd0 : dx_pend_q;
        dy_base   = commit ? 12'sd0 : dy_pend_q;
        dx_pend_d = dx_base;
        dy_pend_d = dy_base;

        if (any_move) begin
            win_cnt_d = '0;
            if (single_key) begin
                if (key_dir == last_dir_q && win_cnt_q < WinEnd) begin
                    step_d = (step_dbl > StepHi) ? StepHi[4:0] : step_dbl[4:0];
                end else begin
                    step_d = StepLo;
                end
                last_dir_d = key_dir;
            end else begin
                step_d     = StepLo;
                last_dir_d = DirNone;
            end
            delta = $signed({7'b0, step_d});
            if (mv_l) dx_pend_d = sat_add(dx_base, -delta);
            if (mv_r) dx_pend_d = sat_add(dx_base, delta);
            if (mv_u) dy_pend_d = sat_add(dy_base, -delta);
            if (mv_d) dy_pend_d = sat_add(dy_base, delta);
        end else begin
            delta = 12'sd0;
        end

        box_x_d     = commit ? clamp_pos(box_x_q, dx_pend_q, XMax) : box_x_q;
        box_y_d     = commit ? clamp_pos(box_y_q, dy_pend_q, YMax) : box_y_q;
        frame_upd_d = commit;
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            box_x_q     <= XReset;
            box_y_q     <= YReset;
            step_q      <= StepLo;
            frame_upd_q <= 1'b0;
            dx_pend_q   <= 12'sd0;
            dy_pend_q   <= 12'sd0;
            last_dir_q  <= DirNone;
            win_cnt_q   <= '0;
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_edge_q   <= 1'b0;
        end else begin
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            step_q      <= step_d;
            frame_upd_q <= frame_upd_d;
            dx_pend_q   <= dx_pend_d;
            dy_pend_q   <= dy_pend_d;
            last_dir_q  <= last_dir_d;
            win_cnt_q   <= win_cnt_d;
            vs_meta_q   <= Vsync;
            vs_sync_q   <= vs_meta_q;
            vs_edge_q   <= vs_sync_q;
        end
    end

    assign Box_x     = box_x_q;
    assign Box_y     = box_y_q;
    assign Step      = step_q;
    assign Frame_upd = frame_upd_q;

endmodule

// File: tb/tb_key_box_position_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_key_box_position_ctrl
//   Scoreboard bench: stimulus updates a behavioural model and pushes the expected commit result
//   into a queue; a monitor pops and compares whenever Frame_upd is seen.
// ---------------------------------------------------------------------------------------------
module tb_key_box_position_ctrl;

    localparam int W    = 2000;
    localparam int XLIM = 576;
    localparam int YLIM = 416;

    logic       clk;
    logic       rst_n;
    logic       k_l, k_r, k_u, k_d;
    logic       vsync;
    logic [9:0] box_x, box_y;
    logic [4:0] step;
    logic       frame_upd;

    key_box_position_ctrl #(
        .ACCEL_WIN(W)
    ) dut (
        .Clk_50mhz(clk),
        .Rst_n    (rst_n),
        .Key_left (k_l),
        .Key_right(k_r),
        .Key_up   (k_u),
        .Key_down (k_d),
        .Vsync    (vsync),
        .Box_x    (box_x),
        .Box_y    (box_y),
        .Step     (step),
        .Frame_upd(frame_upd)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     x;
        int     y;
        int     st;
        longint at;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Model state: plain integers, not the RTL encoding.
    int     m_x, m_y, m_step, m_dx, m_dy;
    int     m_last;       // 0 none, 1 L, 2 R, 3 U, 4 D
    longint m_last_t;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat1023(input int v);
        if (v > 1023) return 1023;
        if (v < -1023) return -1023;
        return v;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 288; m_y = 208; m_step = 1; m_dx = 0; m_dy = 0; m_last = 0; m_last_t = 0;
    endtask

    // k = {left, right, up, down}; t = cycle stamp of the sampling edge.
    task automatic model_press(input logic [3:0] k, input longint t);
        bit l, r, u, d;
        int n, dir;
        l = k[3]; r = k[2]; u = k[1]; d = k[0];
        n = int'(l) + int'(r) + int'(u) + int'(d);
        if (l && r) begin l = 0; r = 0; end
        if (u && d) begin u = 0; d = 0; end
        if (!(l || r || u || d)) return;
        if (n == 1) begin
            dir = l ? 1 : r ? 2 : u ? 3 : 4;
            if (dir == m_last && (t - m_last_t) <= W)
                m_step = (2 * m_step > 16) ? 16 : 2 * m_step;
            else
                m_step = 1;
            m_last = dir;
        end else begin
            m_step = 1;
            m_last = 0;
        end
        m_last_t = t;
        if (l) m_dx = sat1023(m_dx - m_step);
        if (r) m_dx = sat1023(m_dx + m_step);
        if (u) m_dy = sat1023(m_dy - m_step);
        if (d) m_dy = sat1023(m_dy + m_step);
    endtask

    task automatic press(input logic [3:0] k);
        @(posedge clk); #1;
        {k_l, k_r, k_u, k_d} = k;
        @(posedge clk); #1;
        {k_l, k_r, k_u, k_d} = 4'b0;
        model_press(k, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Vsync pulse held for several cycles; optional press landing on the commit edge.
    task automatic do_vsync(input logic [3:0] k_commit);
        longint t0;
        exp_t   e;
        @(posedge clk); #1;
        vsync = 1'b1;
        t0 = cyc;
        m_x = clampi(m_x + m_dx, XLIM);
        m_y = clampi(m_y + m_dy, YLIM);
        m_dx = 0; m_dy = 0;
        @(posedge clk);
        @(posedge clk); #1;
        {k_l, k_r, k_u, k_d} = k_commit;
        @(posedge clk); #1;
        {k_l, k_r, k_u, k_d} = 4'b0;
        model_press(k_commit, t0 + 3);
        e.x = m_x; e.y = m_y; e.st = m_step; e.at = t0 + 3;
        exp_q.push_back(e);
        idle(4);
        #1 vsync = 1'b0;
        idle(5);
    endtask

    // Monitor: Frame_upd sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && frame_upd) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame_upd: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("box_x", box_x, e.x);
                check("box_y", box_y, e.y);
                check("step_at_commit", step, e.st);
                check("commit_latency_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        logic [3:0] k;
        int         r;
        rst_n = 1'b0; vsync = 1'b0;
        {k_l, k_r, k_u, k_d} = 4'b0;
        model_reset();
        idle(3);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_box_x", box_x, m_x);
        check("reset_box_y", box_y, m_y);
        check("reset_step", step, m_step);
        check("reset_frame_upd", frame_upd, 0);

        // 1: zero-displacement commit
        do_vsync(4'b0);
        // 2: three rights, 1000 apart -> 1,2,4
        press(4'b0100); idle(998);
        press(4'b0100); idle(998);
        press(4'b0100);
        do_vsync(4'b0);
        // 3: window expiry between presses
        press(4'b0100); idle(W + 10);
        press(4'b0100);
        do_vsync(4'b0);
        // 4: acceleration + clamping
        for (int i = 0; i < 40; i++) press(4'b1000);
        do_vsync(4'b0);
        for (int i = 0; i < 40; i++) press(4'b0001);
        do_vsync(4'b0);
        // 5: cancel, then diagonal
        press(4'b1100);
        press(4'b0110);
        do_vsync(4'b0);
        // 6: press on the commit edge, then reset with pending displacement
        press(4'b0010);
        do_vsync(4'b0001);
        do_vsync(4'b0);
        for (int i = 0; i < 4; i++) press(4'b0100);
        idle(2);
        #1 rst_n = 1'b0;
        model_reset();
        idle(2);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_box_x", box_x, m_x);
        check("midreset_step", step, m_step);
        do_vsync(4'b0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) k = 4'b1000 >> $urandom_range(0, 3);
            else       k = 4'($urandom_range(1, 15));
            press(k);
            if ($urandom_range(0, 14) == 0) idle(W + $urandom_range(5, 50));
            else                            idle($urandom_range(0, 20));
            r = $urandom_range(0, 5);
            if (r == 0)      do_vsync(4'b0);
            else if (r == 1) do_vsync(4'b1000 >> $urandom_range(0, 3));
        end
        do_vsync(4'b0);

        // Drain, bounded
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d commits outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
